// File: rtl/timer_pkg.sv
// Shared encodings and prescaler decode for the multichannel timer.
package timer_pkg;

  localparam int unsigned PRESCALE_W = 10;
  localparam int unsigned TOV_BIT    = 0;

  localparam int unsigned DIV_8    = 8;
  localparam int unsigned DIV_64   = 64;
  localparam int unsigned DIV_256  = 256;
  localparam int unsigned DIV_1024 = 1024;

  typedef enum logic [2:0] {
    CS_STOP    = 3'b000,
    CS_DIV1    = 3'b001,
    CS_DIV8    = 3'b010,
    CS_DIV64   = 3'b011,
    CS_DIV256  = 3'b100,
    CS_DIV1024 = 3'b101,
    CS_STOP6   = 3'b110,
    CS_STOP7   = 3'b111
  } cs_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_CTC    = 2'b01,
    MODE_RSVD2  = 2'b10,
    MODE_RSVD3  = 2'b11
  } mode_e;

  typedef struct packed {
    logic [2:0] rsvd;
    mode_e      mode;
    logic [2:0] cs;
  } tccr_t;

  // Low prescaler bits that must all be ones for a tick at this divisor.
  function automatic logic [PRESCALE_W-1:0] prescale_mask(input logic [2:0] cs);
    logic [PRESCALE_W-1:0] mask;
    mask = '0;
    case (cs)
      CS_DIV8:    mask = PRESCALE_W'(DIV_8 - 1);
      CS_DIV64:   mask = PRESCALE_W'(DIV_64 - 1);
      CS_DIV256:  mask = PRESCALE_W'(DIV_256 - 1);
      CS_DIV1024: mask = PRESCALE_W'(DIV_1024 - 1);
      default:    mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic cs_running(input logic [2:0] cs);
    logic run;
    run = 1'b0;
    case (cs)
      CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: run = 1'b1;
      default: run = 1'b0;
    endcase
    return run;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 10-bit prescaler producing a one-cycle count enable every N cycles.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       sysClock,
  input  logic       rst_n,
  input  logic [2:0] cs,
  input  logic       clear,
  output logic       tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] mask_c;

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESCALE_W'(1);
    end
  end

  assign mask_c = prescale_mask(cs);

  // Tick decodes from registers only, so clearing aligns the first tick N cycles out.
  assign tick = cs_running(cs) && ((cnt_q & mask_c) == mask_c);

endmodule

// File: rtl/timer_multichannel.sv
// WIDTH-bit timer with NUM_CH output-compare channels, normal/CTC modes and W1C flags.
module timer_multichannel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    sysClock,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        tcnt_wdata,
  input  logic                    tcnt_we,
  input  logic [WIDTH-1:0]        ocr_wdata,
  input  logic [NUM_CH-1:0]       ocr_we,
  input  logic [7:0]              tccr_wdata,
  input  logic                    tccr_we,
  input  logic [NUM_CH:0]         timsk_wdata,
  input  logic                    timsk_we,
  input  logic [NUM_CH:0]         tifr_clr,
  output logic [WIDTH-1:0]        tcnt,
  output logic [NUM_CH*WIDTH-1:0] ocr,
  output logic [7:0]              tccr,
  output logic [NUM_CH:0]         timsk,
  output logic [NUM_CH:0]         tifr,
  output logic                    irq
);

  localparam int unsigned NF = NUM_CH + 1;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  tccr_t            tccr_q;
  logic [WIDTH-1:0] tcnt_q;
  logic [WIDTH-1:0] ocr_q [NUM_CH];
  logic [NF-1:0]    timsk_q;
  logic [NF-1:0]    tifr_q;
  logic [NUM_CH-1:0] match_c;
  logic [NF-1:0]    flag_set_c;
  logic [WIDTH-1:0] top_c;
  logic             tick;

  timer_prescaler u_prescaler (
    .sysClock (sysClock),
    .rst_n    (rst_n),
    .cs       (tccr_q.cs),
    .clear    (tccr_we),
    .tick     (tick)
  );

  // Compare bank: writes take effect immediately, no shadow register.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    always_ff @(posedge sysClock or negedge rst_n) begin
      if (!rst_n) begin
        ocr_q[n] <= '0;
      end else if (ocr_we[n]) begin
        ocr_q[n] <= ocr_wdata;
      end
    end
    assign match_c[n] = (tcnt_q == ocr_q[n]);
    assign ocr[n*WIDTH +: WIDTH] = ocr_q[n];
  end

  assign top_c = (tccr_q.mode == MODE_CTC) ? ocr_q[0] : MAX;

  // A counter preload owns the cycle: no compare or overflow events from the old value.
  always_comb begin
    flag_set_c = '0;
    if (tick && !tcnt_we) begin
      flag_set_c[TOV_BIT] = (tcnt_q == MAX);
      flag_set_c[NF-1:1]  = match_c;
    end
  end

  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      tccr_q  <= '0;
      timsk_q <= '0;
      tifr_q  <= '0;
    end else begin
      if (tcnt_we) begin
        tcnt_q <= tcnt_wdata;
      end else if (tick) begin
        tcnt_q <= (tcnt_q == top_c) ? '0 : tcnt_q + WIDTH'(1);
      end
      if (tccr_we) begin
        tccr_q <= tccr_t'(tccr_wdata);
      end
      if (timsk_we) begin
        timsk_q <= timsk_wdata;
      end
      tifr_q <= (tifr_q & ~tifr_clr) | flag_set_c;
    end
  end

  assign tcnt  = tcnt_q;
  assign tccr  = tccr_q;
  assign timsk = timsk_q;
  assign tifr  = tifr_q;
  assign irq   = |(tifr_q & timsk_q);

endmodule
